// File: rtl/id_stage_banked.sv
// Instruction decode stage: banked register file, bypass/forwarding,
// load-use interlock and a valid/ready ID/EX output register.
module id_stage_banked #(
    parameter int WIDTH = 32,
    parameter int NBANK = 2,
    parameter int BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      ins,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [BW-1:0]    rd_bank,
    input  logic             wr_n,
    input  logic [BW-1:0]    wr_bank,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             fwd_a,
    input  logic             fwd_b,
    input  logic [WIDTH-1:0] fwd_data,
    input  logic             ex_load,
    input  logic [4:0]       ex_rd,
    input  logic [BW-1:0]    ex_bank,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rs_out,
    output logic [WIDTH-1:0] rt_out,
    output logic [WIDTH-1:0] imm_out,
    output logic [WIDTH-1:0] pc_4_out,
    output logic [4:0]       rs_field_out,
    output logic [4:0]       rt_field_out,
    output logic [4:0]       rd_field_out,
    output logic [BW-1:0]    bank_out,
    output logic [15:0]      stall_cnt
);

    logic [WIDTH-1:0] rf [NBANK][32];

    logic [5:0]       op;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [WIDTH-1:0] rs_arr;
    logic [WIDTH-1:0] rt_arr;
    logic [WIDTH-1:0] rs_sel;
    logic [WIDTH-1:0] rt_sel;
    logic [WIDTH-1:0] imm;
    logic             wr_hit;
    logic             hazard;
    logic             accept;

    assign op = ins[31:26];
    assign rs = ins[25:21];
    assign rt = ins[20:16];
    assign rd = ins[15:11];

    // Out-of-range banks read as zero because no bank matches.
    always_comb begin
        rs_arr = '0;
        rt_arr = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (int'(rd_bank) == b) begin
                rs_arr = rf[b][rs];
                rt_arr = rf[b][rt];
            end
        end
    end

    assign wr_hit = !wr_n && (wr_bank == rd_bank);

    always_comb begin
        rs_sel = rs_arr;
        rt_sel = rt_arr;
        if (fwd_a)
            rs_sel = fwd_data;
        else if (wr_hit && wr_addr == rs && rs != 5'd0)
            rs_sel = wr_data;
        if (fwd_b)
            rt_sel = fwd_data;
        else if (wr_hit && wr_addr == rt && rt != 5'd0)
            rt_sel = wr_data;
    end

    always_comb begin
        imm = WIDTH'($signed(ins[15:0]));
        if (op == 6'b001100 || op == 6'b001101 || op == 6'b001110)
            imm = WIDTH'(ins[15:0]);
    end

    assign hazard = ex_load && ex_rd != 5'd0 && ex_bank == rd_bank
                    && (ex_rd == rs || ex_rd == rt);
    assign in_ready = flush || (!hazard && (!out_valid || out_ready));
    assign accept = in_valid && in_ready && !flush;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NBANK; b++)
                for (int r = 0; r < 32; r++)
                    rf[b][r] <= '0;
        end else if (!wr_n) begin
            for (int b = 0; b < NBANK; b++)
                for (int r = 1; r < 32; r++)
                    if (int'(wr_bank) == b && wr_addr == 5'(r))
                        rf[b][r] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            rs_out       <= '0;
            rt_out       <= '0;
            imm_out      <= '0;
            pc_4_out     <= '0;
            rs_field_out <= '0;
            rt_field_out <= '0;
            rd_field_out <= '0;
            bank_out     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            rs_out       <= rs_sel;
            rt_out       <= rt_sel;
            imm_out      <= imm;
            pc_4_out     <= pc_in + WIDTH'(4);
            rs_field_out <= rs;
            rt_field_out <= rt;
            rd_field_out <= rd;
            bank_out     <= rd_bank;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (in_valid && hazard && !flush && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule

// File: tb/tb_id_stage_banked.sv
// Directed bench for id_stage_banked: banks, bypass, immediates,
// interlock, backpressure, flush and asynchronous reset.
module tb_id_stage_banked;

    localparam int WIDTH = 32;
    localparam int BW    = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      ins;
    logic [WIDTH-1:0] pc_in;
    logic [BW-1:0]    rd_bank;
    logic             wr_n;
    logic [BW-1:0]    wr_bank;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] fwd_data;
    logic             ex_load;
    logic [4:0]       ex_rd;
    logic [BW-1:0]    ex_bank;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] rs_out;
    logic [WIDTH-1:0] rt_out;
    logic [WIDTH-1:0] imm_out;
    logic [WIDTH-1:0] pc_4_out;
    logic [4:0]       rs_field_out;
    logic [4:0]       rt_field_out;
    logic [4:0]       rd_field_out;
    logic [BW-1:0]    bank_out;
    logic [15:0]      stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_banked #(.WIDTH(WIDTH), .NBANK(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .ins(ins), .pc_in(pc_in), .rd_bank(rd_bank),
        .wr_n(wr_n), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_data(fwd_data),
        .ex_load(ex_load), .ex_rd(ex_rd), .ex_bank(ex_bank),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rs_out(rs_out), .rt_out(rt_out),
        .imm_out(imm_out), .pc_4_out(pc_4_out),
        .rs_field_out(rs_field_out),
        .rt_field_out(rt_field_out),
        .rd_field_out(rd_field_out),
        .bank_out(bank_out), .stall_cnt(stall_cnt)
    );

    function automatic logic [31:0] mk(input logic [5:0] op,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; wr_n = 1'b1; fwd_a = 1'b0; fwd_b = 1'b0;
        ex_load = 1'b0; flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle();
        ins = '0; pc_in = '0; rd_bank = '0; wr_bank = '0;
        wr_addr = '0; wr_data = '0; fwd_data = '0;
        ex_rd = '0; ex_bank = '0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall got %h want 0", stall_cnt);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
        tick();
    endtask

    task automatic test_bank();
        wr_n = 1'b0; wr_addr = 5'd5;
        wr_bank = 1'b0; wr_data = 32'h1111; tick();
        wr_bank = 1'b1; wr_data = 32'h2222; tick();
        wr_n = 1'b1;
        in_valid = 1'b1; ins = mk(6'h08, 5'd5, 5'd5, 16'h0);
        rd_bank = 1'b1; tick();
        n_checks++;
        if (out_valid !== 1'b1 || rs_out !== 32'h2222) begin
            n_fail++;
            $display("FAIL bank1_r5 got %h v%b want 2222 v1",
                     rs_out, out_valid);
        end
        rd_bank = 1'b0; tick();
        n_checks++;
        if (rs_out !== 32'h1111) begin
            n_fail++;
            $display("FAIL bank0_r5 got %h want 1111", rs_out);
        end
        // write bank0 r5 while reading bank1 r5
        wr_n = 1'b0; wr_bank = 1'b0; wr_data = 32'h3333;
        rd_bank = 1'b1; tick();
        n_checks++;
        if (rt_out !== 32'h2222) begin
            n_fail++;
            $display("FAIL cross_bank got %h want 2222", rt_out);
        end
        wr_addr = 5'd0; wr_data = 32'hFFFF; rd_bank = 1'b0;
        ins = mk(6'h08, 5'd0, 5'd5, 16'h0); tick();
        n_checks++;
        if (rs_out !== 32'h0 || rt_out !== 32'h3333) begin
            n_fail++;
            $display("FAIL r0_same got %h/%h want 0/3333",
                     rs_out, rt_out);
        end
        wr_n = 1'b1; tick();
        n_checks++;
        if (rs_out !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_read got %h want 0", rs_out);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; rd_bank = 1'b0;
        ins = mk(6'h08, 5'd5, 5'd7, 16'h0);
        wr_n = 1'b0; wr_bank = 1'b0; wr_addr = 5'd7;
        wr_data = 32'hABCD; tick();
        n_checks++;
        if (rt_out !== 32'hABCD) begin
            n_fail++;
            $display("FAIL bypass_rt got %h want abcd", rt_out);
        end
        wr_data = 32'h7777; fwd_b = 1'b1; fwd_data = 32'h5; tick();
        n_checks++;
        if (rt_out !== 32'h5 || rs_out !== 32'h3333) begin
            n_fail++;
            $display("FAIL fwd_b got %h/%h want 5/3333",
                     rt_out, rs_out);
        end
        wr_n = 1'b1; fwd_b = 1'b0; fwd_a = 1'b1;
        fwd_data = 32'h9; tick();
        n_checks++;
        if (rs_out !== 32'h9 || rt_out !== 32'h7777) begin
            n_fail++;
            $display("FAIL fwd_a got %h/%h want 9/7777",
                     rs_out, rt_out);
        end
        fwd_a = 1'b0; in_valid = 1'b0; tick();
    endtask

    task automatic test_imm();
        in_valid = 1'b1; pc_in = 32'h100;
        ins = mk(6'b001101, 5'd0, 5'd0, 16'h8001); tick();
        n_checks++;
        if (imm_out !== 32'h00008001 || pc_4_out !== 32'h104) begin
            n_fail++;
            $display("FAIL imm_ori got %h pc4 %h want 00008001 104",
                     imm_out, pc_4_out);
        end
        ins = mk(6'b001000, 5'd0, 5'd0, 16'h8001);
        pc_in = 32'hFFFFFFFC; tick();
        n_checks++;
        if (imm_out !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL imm_addi got %h want ffff8001", imm_out);
        end
        n_checks++;
        if (pc_4_out !== 32'h0) begin
            n_fail++;
            $display("FAIL pc_wrap got %h want 0", pc_4_out);
        end
        ins = mk(6'b001100, 5'd0, 5'd0, 16'hF0F0); tick();
        n_checks++;
        if (imm_out !== 32'h0000F0F0) begin
            n_fail++;
            $display("FAIL imm_andi got %h want 0000f0f0", imm_out);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_interlock();
        in_valid = 1'b1; rd_bank = 1'b0; pc_in = 32'h200;
        ins = {6'h00, 5'd3, 5'd4, 5'd6, 11'h0};
        ex_load = 1'b1; ex_rd = 5'd3; ex_bank = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_ready got %b want 0", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL bubble got v%b cnt %0d want v0 cnt 1",
                     out_valid, stall_cnt);
        end
        ex_load = 1'b0; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hazard_clear got %b want 1", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || rs_field_out !== 5'd3
            || rd_field_out !== 5'd6 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL issue got v%b rs%0d rd%0d cnt%0d want 1 3 6 1",
                     out_valid, rs_field_out, rd_field_out, stall_cnt);
        end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_backpressure_flush();
        in_valid = 1'b1; pc_in = 32'h300;
        ins = mk(6'h08, 5'd7, 5'd0, 16'h1); tick();
        out_ready = 1'b0; pc_in = 32'h400;
        ins = mk(6'h08, 5'd5, 5'd0, 16'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || pc_4_out !== 32'h304
                || imm_out !== 32'h1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold%0d got v%b pc4 %h imm %h r%b",
                         i, out_valid, pc_4_out, imm_out, in_ready);
            end
        end
        flush = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready got %b want 1", in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid got %b want 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || pc_4_out !== 32'h304) begin
            n_fail++;
            $display("FAIL flush_drop got v%b pc4 %h want v0 304",
                     out_valid, pc_4_out);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; rd_bank = 1'b1; pc_in = 32'h500;
        ins = mk(6'h08, 5'd5, 5'd0, 16'h0);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (rs_out !== 32'h2222 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset got %h v%b want 2222 v1",
                     rs_out, out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || rs_out !== 32'h0
            || stall_cnt !== 16'd0 || pc_4_out !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset got v%b rs %h cnt %0d pc4 %h",
                     out_valid, rs_out, stall_cnt, pc_4_out);
        end
        #3 reset = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || rs_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rf_cleared got %h v%b want 0 v1",
                     rs_out, out_valid);
        end
        in_valid = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_bank();
        test_bypass();
        test_imm();
        test_interlock();
        test_backpressure_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_banked.md
# id_stage_banked

Parametrised instruction-decode stage with an NBANK-deep banked register file, write-before-read bypass, EX/MEM forwarding, load-use interlock and a valid/ready ID/EX output register. It sits between the IF stage and the EX stage. Each bank is a separate privilege or context register set, selected per instruction by the mode logic. A saturating stall counter is exposed for performance monitoring.

## Interface
- WIDTH, 32, datapath and register width; minimum 16.
- NBANK, 2, number of 32-entry register banks; minimum 1.
- BW, max(1,$clog2(NBANK)), width of the bank index (derived).

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  the stage accepts on this edge.
- ins  in  32  instruction word; rs=ins[25:21], rt=ins[20:16], rd=ins[15:11], op=ins[31:26].
- pc_in  in  WIDTH  PC of the instruction.
- rd_bank  in  BW  bank used for reads of this instruction.
- wr_n  in  1  active-low register write enable.
- wr_bank  in  BW  write bank.
- wr_addr  in  5  write register.
- wr_data  in  WIDTH  write data.
- fwd_a / fwd_b  in  1  replace the rs / rt operand with fwd_data.
- fwd_data  in  WIDTH  EX/MEM result.
- ex_load  in  1  the instruction now in EX is a load.
- ex_rd  in  5  load destination register.
- ex_bank  in  BW  load destination bank.
- flush  in  1  kill the held output and the current input.
- out_valid  out  1  the ID/EX register holds an instruction.
- out_ready  in  1  EX consumes.
- rs_out, rt_out, imm_out, pc_4_out  out  WIDTH  registered operands, extended immediate, and PC+4.
- rs_field_out, rt_field_out, rd_field_out  out  5  registered register fields.
- bank_out  out  BW  registered rd_bank.
- stall_cnt  out  16  saturating count of interlock cycles.

## Operation
- Register file: NBANK×32 entries of WIDTH bits.
  - Entry 0 of every bank reads 0; writes to entry 0 are dropped.
  - A write occurs on the clk edge when wr_n=0 and wr_bank<NBANK; it is ignored otherwise.
  - A read with rd_bank≥NBANK returns 0.
- Operand select, highest priority first:
  - the fwd flag → fwd_data;
  - write bypass: wr_n=0, wr_bank==rd_bank, wr_addr==field, field≠0 → wr_data;
  - otherwise the array value.
- imm: ins[15:0] zero-extended for op 001100/001101/001110 (andi/ori/xori); sign-extended for all other ops.
- pc_4_out = pc_in+4, modulo 2^WIDTH.
- hazard = ex_load ∧ ex_rd≠0 ∧ ex_bank==rd_bank ∧ (ex_rd==rs ∨ ex_rd==rt).
- in_ready = flush ∨ (¬hazard ∧ (¬out_valid ∨ out_ready)).
- Output register update, per edge:
  - flush=1 → out_valid←0. The current input is consumed and discarded.
  - Accept (in_valid ∧ in_ready ∧ ¬flush) → load all outputs; out_valid←1.
  - Otherwise, if out_ready → out_valid←0 (bubble). Data fields hold their values.
  - Otherwise → hold everything.
- stall_cnt increments on every edge where in_valid ∧ hazard ∧ ¬flush. It saturates at 16'hFFFF.

## Timing
- Reset (reset=0, asynchronous): all bank entries 0; out_valid=0; all data outputs 0; stall_cnt=0. in_ready evaluates to 1 once reset is released. Reset asserted mid-transfer discards the held instruction.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N with out_valid=1.
- Throughput: one instruction per cycle while out_ready=1 and no hazard.
- Load-use interlock: exactly one bubble per hazard cycle. in_ready stays low until ex_load or the match clears.
- Write and read of the same register in the same cycle: the read sees wr_data.
- Write to one bank and read of another bank at the same address: the read sees the old array value.
- out_valid=1 with out_ready=0: all outputs stable. in_ready=0 unless flush.
- flush together with out_ready=0: out_valid still clears.

## Test plan
- Reset: assert reset low mid-stream → out_valid=0, rs_out=0, stall_cnt=0 immediately, without waiting for clk.
- Bank isolation: write bank0 r5=32'h1111 and bank1 r5=32'h2222. Read r5 with rd_bank=1 → rs_out=32'h2222. Write r0=32'hFFFF → reads 0.
- Bypass and forward:
  - wr_n=0, r7=32'hABCD in the same cycle as reading rt=7 → rt_out=32'hABCD.
  - Additionally fwd_b=1, fwd_data=32'h5 → rt_out=32'h5.
- Immediate: ori with imm 16'h8001 → imm_out=32'h00008001. addi with imm 16'h8001 → imm_out=32'hFFFF8001. pc_in=32'hFFFFFFFC → pc_4_out=0.
- Interlock: ex_load=1, ex_rd=3 matching rs=3 for one cycle → in_ready=0, one bubble (out_valid=0), stall_cnt=1. The instruction issues on the next cycle.
- Backpressure and flush: out_ready=0 for 3 cycles → outputs hold and in_ready=0. Then flush=1 → out_valid=0 next edge and the input is dropped.
